// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Op codes, FSM states and op classification for multicycle_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SLT   = 4'h5,
        OP_SLTU  = 4'h6,
        OP_SLL   = 4'h7,
        OP_SRL   = 4'h8,
        OP_SRA   = 4'h9,
        OP_MUL   = 4'hA,
        OP_DIVU  = 4'hB,
        OP_REMU  = 4'hC,
        OP_RSV13 = 4'hD,
        OP_RSV14 = 4'hE,
        OP_RSV15 = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic is_multicycle(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_iter
// Description : Bit-serial shift-add multiplier / restoring divider with counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [3:0]            op_i,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int c_cnt_w = $clog2(DATA_WIDTH);

    logic [c_cnt_w-1:0]    cnt_q;
    logic                  active_q;
    alu_op_t               op_q;
    logic [DATA_WIDTH-1:0] acc_q, x_q, y_q;
    logic [DATA_WIDTH-1:0] acc_d, x_d, y_d;
    logic [DATA_WIDTH:0]   w_shift, w_diff;

    // MUL: acc += x when y[0]; x shifts left, y shifts right.
    // DIVU/REMU: acc is the partial remainder, x shifts dividend out / quotient in.
    always_comb begin
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        w_shift = {acc_q, x_q[DATA_WIDTH-1]};
        w_diff  = w_shift - {1'b0, y_q};
        if (op_q == OP_MUL) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end else begin
            acc_d = w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
            x_d   = {x_q[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
        end
    end

    // Result reflects the iteration being applied this cycle, so the final
    // value is available on the same edge as the last step.
    assign result_o = (op_q == OP_DIVU) ? x_d : acc_d;
    assign last_o   = active_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (load_i) begin
            active_q <= 1'b1;
            cnt_q    <= c_cnt_w'(DATA_WIDTH - 1);
            op_q     <= alu_op_t'(op_i);
            acc_q    <= '0;
            x_q      <= op_a_i;
            y_q      <= op_b_i;
        end else if (active_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu
// Description : Clocked ALU with single-cycle ops and iterative MUL/DIVU/REMU.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            alucontrol,
    input  logic [DATA_WIDTH-1:0] aluop1,
    input  logic [DATA_WIDTH-1:0] aluop2,
    output logic [DATA_WIDTH-1:0] aluout,
    output logic                  zero,
    output logic                  done,
    output logic                  busy
);

    localparam int c_sh_w = $clog2(DATA_WIDTH);

    alu_state_t            state_q;
    logic [DATA_WIDTH-1:0] aluout_q;
    logic                  zero_q, done_q, busy_q;

    alu_op_t               w_op;
    logic [c_sh_w-1:0]     w_shamt;
    logic [DATA_WIDTH-1:0] w_single;
    logic [DATA_WIDTH-1:0] w_iter_result;
    logic                  w_iter_last;
    logic                  w_accept;
    logic                  w_load;

    assign w_op     = alu_op_t'(alucontrol);
    assign w_shamt  = aluop2[c_sh_w-1:0];
    assign w_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign w_load   = start && w_accept && is_multicycle(w_op);

    always_comb begin
        w_single = '0;
        case (w_op)
            OP_ADD:  w_single = aluop1 + aluop2;
            OP_SUB:  w_single = aluop1 - aluop2;
            OP_AND:  w_single = aluop1 & aluop2;
            OP_OR:   w_single = aluop1 | aluop2;
            OP_XOR:  w_single = aluop1 ^ aluop2;
            OP_SLT:  w_single = {{(DATA_WIDTH-1){1'b0}}, $signed(aluop1) < $signed(aluop2)};
            OP_SLTU: w_single = {{(DATA_WIDTH-1){1'b0}}, aluop1 < aluop2};
            OP_SLL:  w_single = aluop1 << w_shamt;
            OP_SRL:  w_single = aluop1 >> w_shamt;
            OP_SRA:  w_single = $signed(aluop1) >>> w_shamt;
            default: w_single = '0;
        endcase
    end

    mul_div_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .op_i     (alucontrol),
        .op_a_i   (aluop1),
        .op_b_i   (aluop2),
        .last_o   (w_iter_last),
        .result_o (w_iter_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            aluout_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        if (is_multicycle(w_op)) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            aluout_q <= w_single;
                            zero_q   <= (w_single == '0);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    done_q <= 1'b0;
                    if (w_iter_last) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        aluout_q <= w_iter_result;
                        zero_q   <= (w_iter_result == '0);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign aluout = aluout_q;
    assign zero   = zero_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_alu
// Description : Scoreboard bench for multicycle_alu with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    localparam int DW = 32;
    localparam int SH = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    alucontrol = 4'h0;
    logic [DW-1:0] aluop1 = '0;
    logic [DW-1:0] aluop2 = '0;
    logic [DW-1:0] aluout;
    logic          zero, done, busy;

    multicycle_alu #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .alucontrol (alucontrol),
        .aluop1     (aluop1),
        .aluop2     (aluop2),
        .aluout     (aluout),
        .zero       (zero),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        int            due;
        bit            multi;
        int            id;
    } exp_t;

    exp_t sbq[$];
    int   ncyc     = 0;
    int   bcnt     = 0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_issued = 0;

    function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [SH-1:0] sh;
        sh = b[SH-1:0];
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'h6: return (a < b) ? 1 : 0;
            4'h7: return a << sh;
            4'h8: return a >> sh;
            4'h9: return $signed(a) >>> sh;
            4'hA: return a * b;
            4'hB: return (b == 0) ? {DW{1'b1}} : a / b;
            4'hC: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic bit is_multi(input logic [3:0] op);
        return (op == 4'hA) || (op == 4'hB) || (op == 4'hC);
    endfunction

    task automatic chk(input string nm, input int id, input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s txn=%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    // Monitor: reset-state checks, then pops the scoreboard on each done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        ncyc = ncyc + 1;
        if (rst) begin
            bcnt = 0;
            chk("rst_aluout", -1, aluout, '0);
            chk("rst_zero", -1, {31'd0, zero}, 1);
            chk("rst_done", -1, {31'd0, done}, 0);
            chk("rst_busy", -1, {31'd0, busy}, 0);
        end else begin
            if (busy) bcnt = bcnt + 1;
            if (done) begin
                if (sbq.size() == 0) begin
                    n_vec = n_vec + 1;
                    n_err = n_err + 1;
                    $display("FAIL unexpected_done cycle=%0d aluout=%h", ncyc, aluout);
                end else begin
                    e = sbq.pop_front();
                    chk("result", e.id, aluout, e.res);
                    chk("zero", e.id, {31'd0, zero}, {31'd0, (e.res == '0)});
                    chk("done_cycle", e.id, ncyc, e.due);
                    chk("busy_cycles", e.id, bcnt, e.multi ? DW : 0);
                end
                bcnt = 0;
            end else if (sbq.size() != 0 && ncyc >= sbq[0].due) begin
                e = sbq.pop_front();
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL missing_done txn=%0d cycle=%0d required_cycle=%0d", e.id, ncyc, e.due);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit push);
        exp_t e;
        @(negedge clk);
        #1;
        start      = 1'b1;
        alucontrol = op;
        aluop1     = a;
        aluop2     = b;
        if (push) begin
            e.res    = model(op, a, b);
            e.multi  = is_multi(op);
            e.due    = ncyc + (e.multi ? DW + 1 : 1);
            e.id     = n_issued;
            n_issued = n_issued + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        release_start();
        for (int i = 0; i < 3 * DW; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b1;
        sbq.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : driver
        logic [3:0]    op;
        logic [DW-1:0] a, b;

        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        issue(4'h0, 5, 7, 1);
        issue(4'h1, 7, 7, 1);
        issue(4'h5, 32'hFFFF_FFFF, 1, 1);
        issue(4'h6, 32'hFFFF_FFFF, 1, 1);
        issue(4'h9, 32'h8000_0000, 4, 1);
        issue(4'h7, 1, 33, 1);
        issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        wait_idle();

        // MUL with an ADD start pulsed mid-run that must be ignored.
        issue(4'hA, 32'hFFFF_FFFF, 3, 1);
        release_start();
        repeat (5) @(negedge clk);
        issue(4'h0, 32'h1111_1111, 32'h2222_2222, 0);
        wait_idle();

        issue(4'hB, 100, 7, 1);
        wait_idle();
        issue(4'hC, 100, 7, 1);
        wait_idle();
        issue(4'hB, 5, 0, 1);
        wait_idle();
        issue(4'hC, 5, 0, 1);
        wait_idle();

        // Reset in the middle of a MUL discards it.
        issue(4'hA, 32'h0001_0001, 32'h0000_0FFF, 1);
        release_start();
        repeat (8) @(negedge clk);
        do_reset();
        issue(4'h0, 1, 1, 1);

        for (int i = 1; i <= 4; i++) begin
            issue(4'h0, i, 10, 1);
        end
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 9)) : DW'($urandom);
            issue(op, a, b, 1);
            if (is_multi(op)) wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog timeout vectors=%0d errors=%0d", n_vec, n_err);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, clocked successor to the combinational ALU. Adds XOR, unsigned compare, shifts, and iterative multiply/divide/remainder behind a start/done handshake. Sits in the execute stage. The control path stalls on `busy` while a multi-cycle operation runs. Single-cycle operations complete with one cycle of latency and can be issued back-to-back.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; must be a power of two and ≥ 8.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only when the block is accepting (state IDLE or DONE).
- `alucontrol`  in  4: operation code, latched on accepted `start`.
- `aluop1`  in  DATA_WIDTH: operand A, latched on accepted `start`.
- `aluop2`  in  DATA_WIDTH: operand B, latched on accepted `start`.
- `aluout`  out  DATA_WIDTH: registered result; holds until the next `done`.
- `zero`  out  1: registered; high when `aluout` == 0; updated together with `aluout`.
- `done`  out  1: one-cycle pulse; `aluout`/`zero` are valid in this cycle.
- `busy`  out  1: high while MUL/DIVU/REMU iterate; `start` is ignored while high.

## Operation
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed), 0110 SLTU
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount = `aluop2[$clog2(DATA_WIDTH)-1:0]`, upper bits ignored
  - 1010 MUL: low DATA_WIDTH bits of the product
  - 1011 DIVU: unsigned quotient
  - 1100 REMU: unsigned remainder
  - 1101–1111: result 0, single-cycle
- Arithmetic wraps modulo 2^DATA_WIDTH. SLT/SLTU produce 1 or 0, zero-extended.
- MUL: shift-add, one bit per cycle, DATA_WIDTH iterations. The low half is sign-agnostic.
- DIVU/REMU: restoring division, one quotient bit per cycle, DATA_WIDTH iterations.
- Divide by zero: DIVU returns all-ones; REMU returns `aluop1`. Latency is unchanged, with no early exit.
- FSM states:
  - IDLE
  - RUN: MUL/DIVU/REMU iterating
  - DONE
- Transitions:
  - IDLE/DONE + `start` + single-cycle op → DONE
  - IDLE/DONE + `start` + MUL/DIVU/REMU → RUN, with the iteration counter loaded to DATA_WIDTH-1
  - IDLE/DONE without `start` → IDLE
  - RUN: counter decrements each cycle; at 0 → DONE
- `done` is high exactly when the state is DONE. `busy` is high exactly when the state is RUN.
- A new `start` in the DONE cycle is accepted, so single-cycle ops can be issued every cycle.
- Operand or `alucontrol` changes during RUN have no effect.
- Reset, including mid-RUN: state IDLE, `aluout` = 0, `zero` = 1, `done` = 0, `busy` = 0. An in-flight operation is discarded and no `done` is produced.

## Timing
- `start` sampled high at edge T (single-cycle op) → `done`, `aluout`, `zero` valid in cycle T+1.
- `start` at edge T (MUL/DIVU/REMU) → `busy` high for cycles T+1…T+DATA_WIDTH, `done` in cycle T+DATA_WIDTH+1. Total latency DATA_WIDTH+1.
- `aluout`/`zero` change only on the edge that enters DONE. Between `done` pulses they are stable.
- Counter width is `$clog2(DATA_WIDTH)`. The transition to DONE occurs on the same edge as the last iteration.

## Structure
- Package `alu_pkg`:
  - `alu_op_t`: 4-bit enum of the op codes above
  - `alu_state_t`: IDLE/RUN/DONE
  - helper function `is_multicycle(alu_op_t)`
- Sub-module `mul_div_iter`: holds the shift-add multiplier, the restoring divider, and the iteration counter.
  - Inputs: load pulse, operands, op select.
  - Outputs: `last` flag and result.
- The top level holds the FSM, the single-cycle datapath, and the output registers.

## Test plan
- Reset, then ADD 5+7 → `done` at T+1, `aluout` = 12, `zero` = 0. Next cycle SUB 7−7 → `aluout` = 0, `zero` = 1.
- SLT(0xFFFFFFFF, 1) → 1; SLTU(0xFFFFFFFF, 1) → 0; SRA(0x80000000, 4) → 0xF8000000; SLL(1, 33) → 2 (amount masked to 1).
- MUL(0xFFFFFFFF, 3) → 0xFFFFFFFD, with `done` exactly 33 cycles after `start` and `busy` high for 32 cycles. A `start` pulsed mid-RUN with ADD is ignored: no extra `done`, result unchanged.
- DIVU(100, 7) → 14; REMU(100, 7) → 2; DIVU(5, 0) → 0xFFFFFFFF; REMU(5, 0) → 5; all with 33-cycle latency.
- `rst` asserted on cycle 10 of a MUL → next cycle `busy` = 0, `aluout` = 0, `zero` = 1, no `done`. A following ADD 1+1 returns 2 at T+1.
- ADD issued on four consecutive cycles (operands 1..4 + 10) → four consecutive `done` pulses with 11, 12, 13, 14. Op 1111 → `aluout` = 0, `zero` = 1.
